// File: rtl/cmat_mult_stream_if.sv
// Operand/result streaming bus for the complex matrix product block.
// The slave view belongs to the block; the master view belongs to the source/sink.
interface cmat_mult_stream_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic                out_last;

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/cmat_mult_stream.sv
// Streams in H (NR x NT) and S (NT x NS), computes Y = H x S with one shared
// complex MAC, and streams Y out row-major with rescaling and saturation.
module cmat_mult_stream #(
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int NR   = 4,
  parameter int NT   = 4,
  parameter int NS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  cmat_mult_stream_if.slave bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o
);
  localparam int NH   = NR * NT;
  localparam int NSE  = NT * NS;
  localparam int NTOT = NH + NSE;
  localparam int CW   = $clog2(NTOT + 1);
  localparam int IW   = (NR > 1) ? $clog2(NR) : 1;
  localparam int JW   = (NS > 1) ? $clog2(NS) : 1;
  localparam int KW   = (NT > 1) ? $clog2(NT) : 1;
  localparam int HAW  = (NH > 1) ? $clog2(NH) : 1;
  localparam int SAW  = (NSE > 1) ? $clog2(NSE) : 1;
  localparam int PW   = 2 * W + 1;
  localparam int AW   = PW + $clog2(NT);

  localparam logic signed [AW-1:0] MAX_A = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_A = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  // Returns {saturated, value}; the arithmetic shift floors toward minus infinity.
  function automatic logic [W:0] shift_sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] sh;
    sh = a >>> FRAC;
    if (sh > MAX_A)      shift_sat = {1'b1, 1'b0, {(W-1){1'b1}}};
    else if (sh < MIN_A) shift_sat = {1'b1, 1'b1, {(W-1){1'b0}}};
    else                 shift_sat = {1'b0, sh[W-1:0]};
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       i_q;
  logic [JW-1:0]       j_q;
  logic [KW-1:0]       k_q;
  logic                in_ready_q, out_valid_q, out_last_q, done_q, ovf_q;
  logic signed [W-1:0] out_re_q, out_im_q;

  logic signed [W-1:0]  h_re_q [NH];
  logic signed [W-1:0]  h_im_q [NH];
  logic signed [W-1:0]  s_re_q [NSE];
  logic signed [W-1:0]  s_im_q [NSE];
  logic signed [AW-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;

  logic [HAW-1:0]       h_rd, h_wr;
  logic [SAW-1:0]       s_rd, s_wr;
  logic signed [PW-1:0] ar, ai, br, bi, pr, pi;
  logic [W:0]           res_re, res_im;
  logic                 in_hs, last_k, last_elem;

  always_comb begin
    h_rd     = HAW'(int'(i_q) * NT + int'(k_q));
    s_rd     = SAW'(int'(k_q) * NS + int'(j_q));
    h_wr     = HAW'(cnt_q);
    s_wr     = SAW'(int'(cnt_q) - NH);
    ar       = PW'(h_re_q[h_rd]);
    ai       = PW'(h_im_q[h_rd]);
    br       = PW'(s_re_q[s_rd]);
    bi       = PW'(s_im_q[s_rd]);
    pr       = ar * br - ai * bi;
    pi       = ar * bi + ai * br;
    acc_re_d = (k_q == '0) ? AW'(pr) : acc_re_q + AW'(pr);
    acc_im_d = (k_q == '0) ? AW'(pi) : acc_im_q + AW'(pi);
    res_re   = shift_sat(acc_re_d);
    res_im   = shift_sat(acc_im_d);
  end

  assign in_hs     = in_ready_q && bus.in_valid;
  assign last_k    = (k_q == KW'(NT - 1));
  assign last_elem = (i_q == IW'(NR - 1)) && (j_q == JW'(NS - 1));

  // Operand storage and accumulator carry no reset; a new job overwrites them.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && in_hs) begin
      if (cnt_q < CW'(NH)) begin
        h_re_q[h_wr] <= bus.in_re;
        h_im_q[h_wr] <= bus.in_im;
      end else begin
        s_re_q[s_wr] <= bus.in_re;
        s_im_q[s_wr] <= bus.in_im;
      end
    end
    if (state_q == MAC) begin
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start coinciding with done is dropped: the job is still retiring.
          if (start_i && !done_q) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
          end
        end
        LOAD: begin
          if (in_hs) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(NTOT - 1)) begin
              state_q    <= MAC;
              in_ready_q <= 1'b0;
              i_q        <= '0;
              j_q        <= '0;
              k_q        <= '0;
            end
          end
        end
        MAC: begin
          if (last_k) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_re_q    <= res_re[W-1:0];
            out_im_q    <= res_im[W-1:0];
            out_last_q  <= last_elem;
            ovf_q       <= ovf_q | res_re[W] | res_im[W];
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= MAC;
              k_q     <= '0;
              if (j_q == JW'(NS - 1)) begin
                j_q <= '0;
                i_q <= i_q + IW'(1);
              end else begin
                j_q <= j_q + JW'(1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_last  = out_last_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign ovf_o         = ovf_q;
endmodule

// File: tb/tb_cmat_mult_stream.sv
// Directed bench for cmat_mult_stream with NR=NT=4, NS=2, W=16, FRAC=8.
module tb_cmat_mult_stream;
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy, done, ovf;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  cmat_mult_stream_if #(.W(16)) bus ();

  cmat_mult_stream #(.W(16), .FRAC(8), .NR(4), .NT(4), .NS(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .bus    (bus),
    .busy_o (busy),
    .done_o (done),
    .ovf_o  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [15:0] h_re [16];
  logic signed [15:0] h_im [16];
  logic signed [15:0] s_re [8];
  logic signed [15:0] s_im [8];
  logic [15:0] got_re [8];
  logic [15:0] got_im [8];
  logic        got_last [8];
  logic [15:0] exp_re [8];
  logic [15:0] exp_im [8];
  int   hs_cyc, first_ov_cyc;
  bit   load_tmo, out_tmo, stall_bad;
  logic done_end;

  task automatic fill_const(input logic [15:0] hr, input logic [15:0] hi,
                            input logic [15:0] sr, input logic [15:0] si);
    for (int e = 0; e < 16; e++) begin h_re[e] = hr; h_im[e] = hi; end
    for (int e = 0; e < 8; e++)  begin s_re[e] = sr; s_im[e] = si; end
  endtask

  task automatic fill_identity();
    fill_const(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    for (int r = 0; r < 4; r++) h_re[r*4+r] = 16'sh0100;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 2; j++) s_re[k*2+j] = 16'((2*k + j + 1) * 256);
  endtask

  function automatic logic [15:0] sat16(input longint a);
    longint v;
    v = a >>> 8;
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic compute_model();
    longint ar, ai;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++) begin
        ar = 0; ai = 0;
        for (int k = 0; k < 4; k++) begin
          ar += longint'(h_re[i*4+k]) * longint'(s_re[k*2+j])
              - longint'(h_im[i*4+k]) * longint'(s_im[k*2+j]);
          ai += longint'(h_re[i*4+k]) * longint'(s_im[k*2+j])
              + longint'(h_im[i*4+k]) * longint'(s_re[k*2+j]);
        end
        exp_re[i*2+j] = sat16(ar);
        exp_im[i*2+j] = sat16(ai);
      end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_job(input bit gaps, input bit glitch);
    int budget;
    load_tmo = 1'b0;
    for (int e = 0; e < 24; e++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.in_valid = 1'b1;
      if (e < 16) begin bus.in_re = h_re[e];    bus.in_im = h_im[e];    end
      else        begin bus.in_re = s_re[e-16]; bus.in_im = s_im[e-16]; end
      start  = glitch && (e == 5);
      budget = 0;
      while (!bus.in_ready && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (!bus.in_ready) load_tmo = 1'b1;
      hs_cyc = cyc;
      @(negedge clk);
      bus.in_valid = 1'b0;
      start        = 1'b0;
    end
  endtask

  task automatic get_outputs(input int n, input int stall_at);
    int got, budget;
    logic [15:0] hold_re, hold_im;
    logic        hold_last;
    got = 0; budget = 0; out_tmo = 1'b0; stall_bad = 1'b0; first_ov_cyc = -1;
    bus.out_ready = 1'b1;
    while (got < n && !out_tmo) begin
      if (bus.out_valid) begin
        if (first_ov_cyc < 0) first_ov_cyc = cyc;
        if (got == stall_at) begin
          bus.out_ready = 1'b0;
          hold_re = bus.out_re; hold_im = bus.out_im; hold_last = bus.out_last;
          repeat (5) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_re !== hold_re || bus.out_im !== hold_im ||
                bus.out_last !== hold_last) stall_bad = 1'b1;
          end
          bus.out_ready = 1'b1;
        end
        got_re[got]   = bus.out_re;
        got_im[got]   = bus.out_im;
        got_last[got] = bus.out_last;
        got++;
        @(negedge clk);
      end else begin
        budget++;
        if (budget > 200) out_tmo = 1'b1;
        @(negedge clk);
      end
    end
    done_end = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_re !== 16'h0)   begin n_fail++; $display("FAIL reset_out_re: got %h want 0000", bus.out_re); end
    n_checks++; if (bus.out_im !== 16'h0)   begin n_fail++; $display("FAIL reset_out_im: got %h want 0000", bus.out_im); end
    n_checks++; if (bus.out_last !== 1'b0)  begin n_fail++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)          begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (ovf !== 1'b0)           begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    fill_identity();
    do_start();
    load_job(1'b0, 1'b0);
    get_outputs(8, -1);
    n_checks++; if (load_tmo || out_tmo) begin n_fail++; $display("FAIL id_timeout: got load=%b out=%b want 0/0", load_tmo, out_tmo); end
    for (int o = 0; o < 8; o++) begin
      n_checks++; if (got_re[o] !== 16'((o + 1) * 256)) begin n_fail++; $display("FAIL id_re[%0d]: got %h want %h", o, got_re[o], 16'((o + 1) * 256)); end
      n_checks++; if (got_im[o] !== 16'h0000) begin n_fail++; $display("FAIL id_im[%0d]: got %h want 0000", o, got_im[o]); end
      n_checks++; if (got_last[o] !== (o == 7)) begin n_fail++; $display("FAIL id_last[%0d]: got %b want %b", o, got_last[o], (o == 7)); end
    end
    n_checks++; if (done_end !== 1'b1) begin n_fail++; $display("FAIL id_done: got %b want 1", done_end); end
    n_checks++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL id_ovf: got %b want 0", ovf); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL id_done_pulse: got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL id_start_on_done: busy got %b want 0", busy); end
  endtask

  task automatic test_complex();
    fill_const(16'h0100, 16'h0100, 16'h0100, 16'hFF00);
    do_start();
    load_job(1'b0, 1'b0);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL cx_in_ready_drop: got %b want 0", bus.in_ready); end
    get_outputs(8, -1);
    n_checks++; if (out_tmo) begin n_fail++; $display("FAIL cx_timeout: got 1 want 0"); end
    n_checks++; if (first_ov_cyc - hs_cyc != 5) begin n_fail++; $display("FAIL cx_latency: got %0d want 5", first_ov_cyc - hs_cyc); end
    for (int o = 0; o < 8; o++) begin
      n_checks++; if (got_re[o] !== 16'h0800 || got_im[o] !== 16'h0000) begin
        n_fail++; $display("FAIL cx_y[%0d]: got %h/%h want 0800/0000", o, got_re[o], got_im[o]); end
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    fill_const(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000);
    do_start();
    load_job(1'b0, 1'b0);
    get_outputs(8, -1);
    for (int o = 0; o < 8; o++) begin
      n_checks++; if (got_re[o] !== 16'h7FFF || got_im[o] !== 16'h0000) begin
        n_fail++; $display("FAIL satA_y[%0d]: got %h/%h want 7fff/0000", o, got_re[o], got_im[o]); end
    end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL satA_ovf: got %b want 1", ovf); end
    @(negedge clk);
    fill_const(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    h_re[0] = 16'shFFFF;
    s_re[0] = 16'sh0001;
    do_start();
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL satB_ovf_clear: got %b want 0", ovf); end
    load_job(1'b0, 1'b0);
    get_outputs(8, -1);
    n_checks++; if (got_re[0] !== 16'hFFFF) begin n_fail++; $display("FAIL satB_floor_re: got %h want ffff", got_re[0]); end
    n_checks++; if (got_im[0] !== 16'h0000) begin n_fail++; $display("FAIL satB_floor_im: got %h want 0000", got_im[0]); end
    n_checks++; if (got_re[1] !== 16'h0000) begin n_fail++; $display("FAIL satB_y01: got %h want 0000", got_re[1]); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL satB_ovf: got %b want 0", ovf); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    for (int e = 0; e < 16; e++) begin
      h_re[e] = 16'(e * 300 - 2000);
      h_im[e] = 16'(1500 - e * 170);
    end
    for (int e = 0; e < 8; e++) begin
      s_re[e] = 16'(e * 450 - 1700);
      s_im[e] = 16'(900 - e * 260);
    end
    compute_model();
    do_start();
    load_job(1'b1, 1'b0);
    get_outputs(8, 3);
    n_checks++; if (load_tmo || out_tmo) begin n_fail++; $display("FAIL bp_timeout: got load=%b out=%b want 0/0", load_tmo, out_tmo); end
    n_checks++; if (stall_bad) begin n_fail++; $display("FAIL bp_stall_stable: got changed want stable"); end
    for (int o = 0; o < 8; o++) begin
      n_checks++; if (got_re[o] !== exp_re[o] || got_im[o] !== exp_im[o]) begin
        n_fail++; $display("FAIL bp_y[%0d]: got %h/%h want %h/%h", o, got_re[o], got_im[o], exp_re[o], exp_im[o]); end
    end
    n_checks++; if (got_last[7] !== 1'b1 || done_end !== 1'b1) begin
      n_fail++; $display("FAIL bp_last_done: got last=%b done=%b want 1/1", got_last[7], done_end); end
    @(negedge clk);
  endtask

  task automatic test_reset_midjob();
    fill_identity();
    do_start();
    load_job(1'b0, 1'b0);
    get_outputs(4, -1);
    n_checks++; if (got_re[3] !== 16'h0400) begin n_fail++; $display("FAIL rm_pre_y3: got %h want 0400", got_re[3]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b0)  begin n_fail++; $display("FAIL rm_in_ready: got %b want 0", bus.in_ready); end
    do_start();
    load_job(1'b1, 1'b1);
    get_outputs(8, -1);
    n_checks++; if (load_tmo || out_tmo) begin n_fail++; $display("FAIL rm_timeout: got load=%b out=%b want 0/0", load_tmo, out_tmo); end
    for (int o = 0; o < 8; o++) begin
      n_checks++; if (got_re[o] !== 16'((o + 1) * 256) || got_im[o] !== 16'h0000) begin
        n_fail++; $display("FAIL rm_y[%0d]: got %h/%h want %h/0000", o, got_re[o], got_im[o], 16'((o + 1) * 256)); end
    end
    n_checks++; if (done_end !== 1'b1) begin n_fail++; $display("FAIL rm_done: got %b want 1", done_end); end
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_identity();
    test_complex();
    test_saturation();
    test_backpressure();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule
